ed_register_stage: RTL
======================

// Module: ed_register_stage
// PURPOSE
//  Timing-error-detecting register bank driven by the resilient pipeline controller:
//  consumes the controller's capture pulse (clk output) and sample window, produces the two-phase Err0/Err1 status.
//  Main register captures on cap_i; shadow copy taken at sample rise; mismatch = timing error.
//  Reports each error on alternating phase lines and optionally corrects q_o from the shadow copy.
// PARAMETERS
//  WIDTH    16  datapath width in bits
//  CNT_W    8   width of saturating error counter
//  CORRECT  1   1: overwrite q_o with shadow value on mismatch; 0: detect only
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      synchronous, active-low reset
//  cap_i     in   1      capture pulse from controller (main register enable)
//  sample_i  in   1      sample window level from controller; high = evaluation window
//  d_i       in   WIDTH  combinational stage result
//  q_o       out  WIDTH  registered data to next stage
//  Err0      out  1      error report, phase 0 evaluations
//  Err1      out  1      error report, phase 1 evaluations
//  phase_o   out  1      phase of the next evaluation (0 -> Err0, 1 -> Err1)
//  err_cnt_o out  CNT_W  saturating count of detected mismatches
//  viol_o    out  1      sticky protocol-violation flag
// BEHAVIOUR
//  Reset (rst==0 at edge): q_o=0, shadow=0, Err0=Err1=0, phase_o=0, err_cnt_o=0, viol_o=0, sample_q=0, state=S_IDLE.
//  sample_q = sample_i registered; rise = sample_i & ~sample_q, fall = ~sample_i & sample_q.
//  FSM: S_IDLE -> S_HELD on cap_i; S_HELD -> S_EVAL on rise; S_EVAL -> S_IDLE on fall.
//  S_IDLE, cap_i in cycle n: q_o <= d_i, visible n+1. rise in S_IDLE: viol_o<=1, no evaluation.
//  S_HELD, rise in cycle n: shadow <= d_i; mis = (d_i != q_o); at n+1:
//   Err[phase_o] <= mis; other Err line stays 0; if mis & CORRECT, q_o <= d_i;
//   if mis, err_cnt_o <= err_cnt_o+1, saturates at all-ones (no wrap).
//  S_EVAL: Err line held while sample_i high; fall in cycle m -> at m+1 both Err=0, phase_o toggles, state S_IDLE.
//  Phase toggles after every evaluation, error or not.
//  cap_i in S_HELD or S_EVAL: ignored, viol_o<=1. cap_i and fall same cycle in S_EVAL: fall taken, cap ignored, viol_o<=1.
//  cap_i and rise same cycle in S_IDLE: capture taken, rise flagged viol_o<=1, state S_HELD.
//  viol_o cleared only by reset. Reset mid-window: all state to reset values next edge; Err dropped immediately.
//  No combinational path input->output; every output is a flop.
// STRUCTURE
//  Shared package ed_pkg: state encoding S_IDLE=2'd0, S_HELD=2'd1, S_EVAL=2'd2; default WIDTH/CNT_W constants.
//  One sub-module: ed_sat_counter (CNT_W, inc, rst) for err_cnt_o. FSM, edge detect and registers stay in top.
// TESTING
//  1 rst=0 3 cycles, d_i=16'hFFFF, cap_i=1 -> all outputs 0, state S_IDLE after rst=1.
//  2 cap_i with d_i=16'h1234, hold d_i, sample_i high 3 cycles -> q_o=16'h1234 next cycle, Err0=Err1=0, phase_o 0->1 after fall.
//  3 cap_i d_i=16'h00AA, change d_i=16'h00AB before sample rise (phase 0) -> Err0=1 during window, q_o=16'h00AB, err_cnt_o=1; next mismatch asserts Err1, err_cnt_o=2.
//  4 CNT_W=2, five mismatching evaluations -> err_cnt_o 1,2,3,3,3 (saturates, no wrap).
//  5 rst=0 for one cycle during S_EVAL with Err1=1 -> next edge Err1=0, phase_o=0, q_o=0, err_cnt_o=0.
//  6 cap_i pulse during S_EVAL; separately rise in S_IDLE -> viol_o=1 sticky, q_o unchanged by the ignored cap.

Source files
------------

// File: rtl/ed_pkg.sv
// Shared types and default sizes for the timing-error-detecting register stage.
package ed_pkg;

   localparam int unsigned ED_WIDTH = 16;
   localparam int unsigned ED_CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HELD = 2'd1,
      S_EVAL = 2'd2
   } ed_state_t;

endpackage : ed_pkg

// File: rtl/ed_sat_counter.sv
// Saturating up-counter for detected mismatches; sticks at all-ones, never wraps.
module ed_sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign cnt_o = r_cnt;

endmodule : ed_sat_counter

// File: rtl/ed_register_stage.sv
// Error-detecting register: main capture on cap_i, shadow sample at window rise,
// mismatch reported on alternating Err0/Err1 lines with optional correction.
module ed_register_stage
   import ed_pkg::*;
#(
   parameter int unsigned WIDTH   = ED_WIDTH,
   parameter int unsigned CNT_W   = ED_CNT_W,
   parameter bit          CORRECT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap_i,
   input  logic             sample_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             Err0,
   output logic             Err1,
   output logic             phase_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             viol_o
);

   ed_state_t        r_state,  w_state_nx;
   logic [WIDTH-1:0] r_q,      w_q_nx;
   logic [WIDTH-1:0] r_shadow, w_shadow_nx;
   logic             r_err0,   w_err0_nx;
   logic             r_err1,   w_err1_nx;
   logic             r_phase,  w_phase_nx;
   logic             r_viol,   w_viol_nx;
   logic             r_sample_q;
   logic             w_rise, w_fall, w_mis, w_inc;

   assign w_rise = sample_i & ~r_sample_q;
   assign w_fall = ~sample_i & r_sample_q;
   assign w_mis  = (d_i != r_q);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_q        <= '0;
         r_shadow   <= '0;
         r_err0     <= 1'b0;
         r_err1     <= 1'b0;
         r_phase    <= 1'b0;
         r_viol     <= 1'b0;
         r_sample_q <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_q        <= w_q_nx;
         r_shadow   <= w_shadow_nx;
         r_err0     <= w_err0_nx;
         r_err1     <= w_err1_nx;
         r_phase    <= w_phase_nx;
         r_viol     <= w_viol_nx;
         r_sample_q <= sample_i;
      end
   end

   // Next-state and next-value logic
   always_comb begin
      w_state_nx  = r_state;
      w_q_nx      = r_q;
      w_shadow_nx = r_shadow;
      w_err0_nx   = r_err0;
      w_err1_nx   = r_err1;
      w_phase_nx  = r_phase;
      w_viol_nx   = r_viol;
      w_inc       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cap_i) begin
               w_q_nx     = d_i;
               w_state_nx = S_HELD;
            end
            if (w_rise) w_viol_nx = 1'b1;
         end
         S_HELD: begin
            if (cap_i) w_viol_nx = 1'b1;
            if (w_rise) begin
               w_shadow_nx = d_i;
               w_err0_nx   = w_mis & ~r_phase;
               w_err1_nx   = w_mis &  r_phase;
               w_inc       = w_mis;
               if (w_mis && CORRECT) w_q_nx = d_i;
               w_state_nx  = S_EVAL;
            end
         end
         S_EVAL: begin
            if (cap_i) w_viol_nx = 1'b1;
            // Corrected value is held from the shadow copy for the whole window
            if (CORRECT && (r_err0 || r_err1)) w_q_nx = r_shadow;
            if (w_fall) begin
               w_err0_nx  = 1'b0;
               w_err1_nx  = 1'b0;
               w_phase_nx = ~r_phase;
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   ed_sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc),
      .cnt_o (err_cnt_o)
   );

   assign q_o     = r_q;
   assign Err0    = r_err0;
   assign Err1    = r_err1;
   assign phase_o = r_phase;
   assign viol_o  = r_viol;

endmodule : ed_register_stage
